// File: rtl/hex_grid_scan_ctrl.sv
// Frame sequencer for the hex-to-screen transform: snapshots frame config, walks every
// axial cell of a hexagonal region over valid/ready, and tracks returning results.
//   state | meaning
//   IDLE  | no frame in progress
//   LOAD  | iterator initialised from the latched radius
//   ISSUE | presenting cells to the transform
//   DRAIN | all cells issued, waiting for outstanding results
//   DONE  | frame complete; holds until start or abort
module hex_grid_scan_ctrl #(
  parameter int RAD_W   = 8,
  parameter int CNT_W   = 20,
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] center_q,
  input  logic [COORD_W-1:0] center_r,
  input  logic [RAD_W-1:0]   radius,
  input  logic [31:0]        cfg_hex_size_in,
  input  logic [31:0]        cfg_cam_x_in,
  input  logic [31:0]        cfg_cam_y_in,
  input  logic [31:0]        cfg_zoom_in,
  output logic [31:0]        cfg_hex_size,
  output logic [31:0]        cfg_cam_x,
  output logic [31:0]        cfg_cam_y,
  output logic [31:0]        cfg_zoom,
  output logic               cell_valid,
  input  logic               cell_ready,
  output logic [31:0]        cell_q_f,
  output logic [31:0]        cell_r_f,
  input  logic               res_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cells_issued,
  output logic               overflow
);

  // Iterator offsets span -R..+R, and -dq+R reaches 2R, so two extra bits cover sign and range.
  localparam int DW = RAD_W + 2;
  localparam logic signed [DW-1:0] ZERO = '0;
  localparam logic signed [DW-1:0] ONE  = DW'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic signed [COORD_W-1:0] ctr_q, ctr_r, q_sum, r_sum;
  logic        [RAD_W-1:0]   rad;
  logic signed [DW-1:0]      rad_s, dq, dr, dq_inc, dr_max, dr_min_nxt;
  logic        [CNT_W-1:0]   received, rcv_nxt;
  logic                      in_frame, xfer, last_cell, res_ok, start_acc;

  assign rad_s     = $signed({2'b00, rad});
  assign in_frame  = (state == S_LOAD) || (state == S_ISSUE) || (state == S_DRAIN);
  assign xfer      = (state == S_ISSUE) && cell_ready;
  assign res_ok    = res_valid && in_frame && (received != cells_issued);
  assign rcv_nxt   = received + CNT_W'(res_ok);
  assign start_acc = start && ((state == S_IDLE) || ((state == S_DONE) && !abort));

  always_comb begin
    dq_inc     = dq + ONE;
    dr_max     = (dq > ZERO) ? rad_s - dq : rad_s;
    dr_min_nxt = (dq_inc > ZERO) ? -rad_s : -dq_inc - rad_s;
    last_cell  = (dr == dr_max) && (dq == rad_s);
    q_sum      = ctr_q + COORD_W'(dq);
    r_sum      = ctr_r + COORD_W'(dr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = abort ? S_IDLE : S_ISSUE;
      S_ISSUE: begin
        if (abort)                  state_nxt = S_IDLE;
        else if (xfer && last_cell) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                        state_nxt = S_IDLE;
        else if (rcv_nxt == cells_issued) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (abort)      state_nxt = S_IDLE;
        else if (start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cell_valid = (state == S_ISSUE);
    busy       = in_frame;
    done       = (state == S_DONE);
    cell_q_f   = cell_valid ? {16'(q_sum), 16'h0} : '0;
    cell_r_f   = cell_valid ? {16'(r_sum), 16'h0} : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_q        <= '0;
      ctr_r        <= '0;
      rad          <= '0;
      dq           <= '0;
      dr           <= '0;
      cfg_hex_size <= '0;
      cfg_cam_x    <= '0;
      cfg_cam_y    <= '0;
      cfg_zoom     <= '0;
      cells_issued <= '0;
      received     <= '0;
      overflow     <= 1'b0;
    end else if (start_acc) begin
      ctr_q        <= $signed(center_q);
      ctr_r        <= $signed(center_r);
      rad          <= radius;
      cfg_hex_size <= cfg_hex_size_in;
      cfg_cam_x    <= cfg_cam_x_in;
      cfg_cam_y    <= cfg_cam_y_in;
      cfg_zoom     <= cfg_zoom_in;
      cells_issued <= '0;
      received     <= '0;
      overflow     <= 1'b0;
    end else begin
      if (state == S_LOAD) begin
        dq <= -rad_s;
        dr <= ZERO;
      end
      // A transfer coinciding with abort still advances and counts.
      if (xfer) begin
        cells_issued <= cells_issued + CNT_W'(1);
        if (dr == dr_max) begin
          dq <= dq_inc;
          dr <= dr_min_nxt;
        end else begin
          dr <= dr + ONE;
        end
      end
      if (res_valid && in_frame) begin
        if (received == cells_issued) overflow <= 1'b1;
        else                          received <= rcv_nxt;
      end
    end
  end

endmodule

// File: tb/tb_hex_grid_scan_ctrl.sv
// Directed bench for hex_grid_scan_ctrl: a 3-stage pipe stands in for the transform,
// expected cell sequences come from a hand table or an independent region walk.
module tb_hex_grid_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] center_q = '0;
  logic [15:0] center_r = '0;
  logic [7:0]  radius = '0;
  logic [31:0] cfg_hex_size_in = 32'h0020_0000;
  logic [31:0] cfg_cam_x_in = 32'h0003_0000;
  logic [31:0] cfg_cam_y_in = 32'hFFFE_8000;
  logic [31:0] cfg_zoom_in = 32'h0001_0000;
  logic [31:0] cfg_hex_size, cfg_cam_x, cfg_cam_y, cfg_zoom;
  logic        cell_valid;
  logic        cell_ready = 1'b1;
  logic [31:0] cell_q_f, cell_r_f;
  logic        res_valid;
  logic        busy, done, overflow;
  logic [19:0] cells_issued;

  logic        auto_res = 1'b1;
  logic        man_res = 1'b0;
  logic [2:0]  pipe;
  logic [3:0]  pat = 4'b1001;
  int          checks = 0;
  int          errors = 0;
  int          rc = 0;
  int          stall_bad = 0;
  logic [63:0] got[$];
  logic [63:0] expc[$];

  hex_grid_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .center_q(center_q), .center_r(center_r), .radius(radius),
    .cfg_hex_size_in(cfg_hex_size_in), .cfg_cam_x_in(cfg_cam_x_in),
    .cfg_cam_y_in(cfg_cam_y_in), .cfg_zoom_in(cfg_zoom_in),
    .cfg_hex_size(cfg_hex_size), .cfg_cam_x(cfg_cam_x), .cfg_cam_y(cfg_cam_y),
    .cfg_zoom(cfg_zoom), .cell_valid(cell_valid), .cell_ready(cell_ready),
    .cell_q_f(cell_q_f), .cell_r_f(cell_r_f), .res_valid(res_valid),
    .busy(busy), .done(done), .cells_issued(cells_issued), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) pipe <= '0;
    else       pipe <= {pipe[1:0], cell_valid & cell_ready};
  end
  assign res_valid = auto_res ? pipe[2] : man_res;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build_exp(input int cq, input int cr, input int r);
    logic [31:0] qf, rf;
    int lo, hi;
    expc.delete();
    for (int q = -r; q <= r; q++) begin
      lo = (-q - r > -r) ? -q - r : -r;
      hi = (-q + r < r) ? -q + r : r;
      for (int d = lo; d <= hi; d++) begin
        qf = (cq + q) << 16;
        rf = (cr + d) << 16;
        expc.push_back({qf, rf});
      end
    end
  endtask

  // Records every handshake; returns at the first negedge after cell_valid falls.
  task automatic collect(input bit toggle);
    bit seen, stalled;
    logic [31:0] pq, pr;
    int k;
    got.delete();
    seen = 1'b0; stalled = 1'b0; pq = '0; pr = '0; k = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (res_valid) rc++;
      cell_ready = toggle ? pat[k % 4] : 1'b1;
      k++;
      if (stalled && (!cell_valid || cell_q_f !== pq || cell_r_f !== pr)) stall_bad++;
      if (cell_valid) seen = 1'b1;
      if (seen && !cell_valid) break;
      if (cell_valid && cell_ready) got.push_back({cell_q_f, cell_r_f});
      stalled = cell_valid && !cell_ready;
      pq = cell_q_f;
      pr = cell_r_f;
    end
    cell_ready = 1'b1;
  endtask

  task automatic check_cells(input string tag);
    chk({tag, "_count"}, 64'(got.size()), 64'(expc.size()));
    for (int i = 0; i < got.size() && i < expc.size(); i++)
      chk($sformatf("%s_cell%0d", tag, i), got[i], expc[i]);
  endtask

  task automatic wait_done(input int maxcyc);
    for (int c = 0; c < maxcyc; c++) begin
      @(negedge clk);
      if (done) break;
      if (res_valid) rc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(cell_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_issued", 64'(cells_issued), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_zoom", 64'(cfg_zoom), 0);
    chk("rst_qf", 64'(cell_q_f), 0);
    reset = 1'b0;

    // R=1 around the origin, ready always high; zoom input changes mid-frame
    center_q = 16'h0000; center_r = 16'h0000; radius = 8'd1; rc = 0;
    pulse_start();
    chk("t1_load_busy", 64'(busy), 1);
    chk("t1_load_valid", 64'(cell_valid), 0);
    cfg_zoom_in = 32'h0002_0000;
    collect(1'b0);
    expc = '{64'hFFFF0000_00000000, 64'hFFFF0000_00010000, 64'h00000000_FFFF0000,
             64'h00000000_00000000, 64'h00000000_00010000, 64'h00010000_FFFF0000,
             64'h00010000_00000000};
    check_cells("t1");
    chk("t1_issued", 64'(cells_issued), 7);
    chk("t1_drain_not_done", 64'(done), 0);
    wait_done(50);
    chk("t1_done", 64'(done), 1);
    chk("t1_results_before_done", 64'(rc), 7);
    chk("t1_busy_low", 64'(busy), 0);
    chk("t1_zoom_frozen", 64'(cfg_zoom), 64'h0001_0000);
    chk("t1_hex_size", 64'(cfg_hex_size), 64'h0020_0000);
    chk("t1_cam_x", 64'(cfg_cam_x), 64'h0003_0000);
    chk("t1_cam_y", 64'(cfg_cam_y), 64'hFFFE_8000);
    chk("t1_overflow", 64'(overflow), 0);
    repeat (3) @(negedge clk);
    chk("t1_done_hold", 64'(done), 1);

    // R=0 single cell at (5,-3)
    center_q = 16'h0005; center_r = 16'hFFFD; radius = 8'd0; rc = 0;
    pulse_start();
    chk("t2_load_busy", 64'(busy), 1);
    chk("t2_load_valid", 64'(cell_valid), 0);
    chk("t2_load_done", 64'(done), 0);
    @(negedge clk);
    chk("t2_issue_valid", 64'(cell_valid), 1);
    chk("t2_issue_q", 64'(cell_q_f), 64'h0005_0000);
    chk("t2_issue_r", 64'(cell_r_f), 64'hFFFD_0000);
    @(negedge clk);
    chk("t2_drain_valid", 64'(cell_valid), 0);
    chk("t2_drain_busy", 64'(busy), 1);
    chk("t2_drain_done", 64'(done), 0);
    chk("t2_issued", 64'(cells_issued), 1);
    wait_done(20);
    chk("t2_done", 64'(done), 1);
    chk("t2_results", 64'(rc), 1);
    chk("t2_zoom_new", 64'(cfg_zoom), 64'h0002_0000);

    // R=2 at (3,-1) with ready pattern 1,0,0,1
    center_q = 16'h0003; center_r = 16'hFFFF; radius = 8'd2; rc = 0; stall_bad = 0;
    pulse_start();
    collect(1'b1);
    build_exp(3, -1, 2);
    check_cells("t3");
    chk("t3_stall_stable", 64'(stall_bad), 0);
    chk("t3_issued", 64'(cells_issued), 19);
    wait_done(100);
    chk("t3_done", 64'(done), 1);
    chk("t3_results", 64'(rc), 19);

    // abort coinciding with the third transfer
    center_q = 16'h0000; center_r = 16'h0000; radius = 8'd1;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t4_pre_abort_issued", 64'(cells_issued), 2);
    chk("t4_pre_abort_valid", 64'(cell_valid), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_valid", 64'(cell_valid), 0);
    chk("t4_abort_busy", 64'(busy), 0);
    chk("t4_abort_done", 64'(done), 0);
    chk("t4_abort_issued", 64'(cells_issued), 3);
    repeat (6) @(negedge clk);
    chk("t4_idle_hold", 64'(busy), 0);
    center_q = 16'hFFFE; center_r = 16'h0004; radius = 8'd1; rc = 0;
    pulse_start();
    chk("t4_restart_cleared", 64'(cells_issued), 0);
    collect(1'b0);
    build_exp(-2, 4, 1);
    check_cells("t4");
    wait_done(50);
    chk("t4_done", 64'(done), 1);
    chk("t4_issued", 64'(cells_issued), 7);
    chk("t4_results", 64'(rc), 7);
    chk("t4_overflow", 64'(overflow), 0);

    // reset during DRAIN, then an unsolicited result
    center_q = 16'h0000; center_r = 16'h0000; radius = 8'd1;
    pulse_start();
    collect(1'b0);
    chk("t5_in_drain", 64'(busy), 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(cell_valid), 0);
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_done", 64'(done), 0);
    chk("t5_rst_issued", 64'(cells_issued), 0);
    @(negedge clk);
    reset = 1'b0;
    auto_res = 1'b0;
    radius = 8'd0;
    pulse_start();
    man_res = 1'b1;
    @(negedge clk);
    man_res = 1'b0;
    chk("t5_overflow_set", 64'(overflow), 1);
    chk("t5_issue_valid", 64'(cell_valid), 1);
    @(negedge clk);
    chk("t5_drain_busy", 64'(busy), 1);
    chk("t5_drain_done", 64'(done), 0);
    man_res = 1'b1;
    @(negedge clk);
    man_res = 1'b0;
    chk("t5_done", 64'(done), 1);
    chk("t5_overflow_sticky", 64'(overflow), 1);
    pulse_start();
    chk("t5_overflow_cleared", 64'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
